// File: rtl/mdio_pkg.sv
// Shared constants, opcodes and FSM state encoding for the MDIO management interface.
// Used by the controller RTL and by its testbench.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int FRAME_LEN = 32;
  localparam int ADDR_BITS = 14;
  localparam int DATA_BITS = 16;
  localparam int TURN_BITS = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    TURN  = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } mdio_state_t;

endpackage

// File: rtl/mdio_clk_gen.sv
// Free-running MDC at CLK/2 with one-CLK strobes.
// Each strobe marks the cycle whose closing CLK edge moves MDC in that direction.
module mdio_clk_gen (
  input  logic clk,
  input  logic rst_n,
  output logic mdc,
  output logic mdc_fall,
  output logic mdc_rise
);

  logic mdc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_reg <= 1'b0;
    end else begin
      mdc_reg <= ~mdc_reg;
    end
  end

  assign mdc      = mdc_reg;
  assign mdc_fall = mdc_reg;
  assign mdc_rise = ~mdc_reg;

endmodule

// File: rtl/mdio_controller.sv
// MDIO management frame controller: shifts out a 32-bit frame MSB first with no
// preamble and, for read opcodes, releases the line and collects 16 data bits.
module mdio_controller
  import mdio_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] T_DATA,
  input  logic        T_STB,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  mdio_state_t          state_reg, state_next;
  logic [5:0]           cnt_reg, cnt_next;
  logic [31:0]          shift_reg, shift_next;
  logic                 out_reg, out_next;
  logic                 oe_reg, oe_next;
  logic [DATA_BITS-1:0] rd_shift_reg, rd_shift_next;
  logic [DATA_BITS-1:0] rd_data_reg, rd_data_next;
  logic                 is_read_reg, is_read_next;
  logic                 mdc_fall;
  logic                 mdc_rise;

  mdio_clk_gen u_clk_gen (
    .clk      (CLK),
    .rst_n    (RESET),
    .mdc      (MDC),
    .mdc_fall (mdc_fall),
    .mdc_rise (mdc_rise)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      out_reg      <= 1'b0;
      oe_reg       <= 1'b0;
      rd_shift_reg <= '0;
      rd_data_reg  <= '0;
      is_read_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      out_reg      <= out_next;
      oe_reg       <= oe_next;
      rd_shift_reg <= rd_shift_next;
      rd_data_reg  <= rd_data_next;
      is_read_reg  <= is_read_next;
    end
  end

  // cnt_reg holds the number of MDC periods already started in this frame;
  // every line change happens on an mdc_fall cycle.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    out_next      = out_reg;
    oe_next       = oe_reg;
    rd_shift_next = rd_shift_reg;
    rd_data_next  = rd_data_reg;
    is_read_next  = is_read_reg;
    case (state_reg)
      IDLE: begin
        if (T_STB) begin
          shift_next   = T_DATA;
          cnt_next     = '0;
          is_read_next = (T_DATA[29:28] == OP_READ);
          state_next   = ADDR;
        end
      end
      ADDR: begin
        if (mdc_fall) begin
          out_next   = shift_reg[31];
          oe_next    = 1'b1;
          shift_next = {shift_reg[30:0], 1'b0};
          cnt_next   = cnt_reg + 6'd1;
          if (cnt_reg == 6'(ADDR_BITS - 1)) begin
            state_next = is_read_reg ? TURN : WRITE;
          end
        end
      end
      TURN: begin
        if (mdc_fall) begin
          out_next = 1'b0;
          oe_next  = 1'b0;
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'(ADDR_BITS + TURN_BITS - 1)) begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (mdc_fall) begin
          if (cnt_reg == 6'(FRAME_LEN)) begin
            rd_data_next = rd_shift_reg;
            state_next   = DONE;
          end else begin
            cnt_next = cnt_reg + 6'd1;
          end
        end else if (mdc_rise && (cnt_reg > 6'(ADDR_BITS + TURN_BITS))) begin
          // Only rises inside a data period; the second turnaround period is skipped.
          rd_shift_next = {rd_shift_reg[DATA_BITS-2:0], MDIO_IN};
        end
      end
      WRITE: begin
        if (mdc_fall) begin
          if (cnt_reg == 6'(FRAME_LEN)) begin
            out_next   = 1'b0;
            oe_next    = 1'b0;
            state_next = DONE;
          end else begin
            out_next   = shift_reg[31];
            oe_next    = 1'b1;
            shift_next = {shift_reg[30:0], 1'b0};
            cnt_next   = cnt_reg + 6'd1;
          end
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign MDIO_OUT = out_reg;
  assign MDIO_OE  = oe_reg;
  assign RD_DATA  = rd_data_reg;
  assign DATA_RDY = (state_reg == DONE) && is_read_reg;
  assign BUSY     = (state_reg != IDLE) && (state_reg != DONE);

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port T_DATA, input, 32, frame word: [31:30] ST, [29:28] OP, [27:23] PHYADR, [22:18] REGADR, [17:16] TA, [15:0] write data.
REQ-004 SHALL have port T_STB, input, 1, start request; T_DATA is captured on the same CLK edge.
REQ-005 SHALL have port MDIO_IN, input, 1, serial data returned by the PHY-side receptor.
REQ-006 SHALL have port MDC, output, 1, management clock at CLK/2.
REQ-007 SHALL have port MDIO_OUT, output, 1, serial frame bit.
REQ-008 SHALL have port MDIO_OE, output, 1, high while the controller drives MDIO.
REQ-009 SHALL have port RD_DATA, output, 16, data word assembled during a read.
REQ-010 SHALL have port DATA_RDY, output, 1, one-CLK pulse when RD_DATA is valid.
REQ-011 SHALL have port BUSY, output, 1, high from frame acceptance until frame end.

Function
REQ-012 MDC SHALL be free-running and toggle on every CLK rising edge after reset release; each MDC period equals 2 CLK cycles.
REQ-013 The FSM SHALL have states IDLE, ADDR, TURN, READ, WRITE and DONE.
REQ-014 In IDLE, T_STB=1 SHALL latch T_DATA into a 32-bit shift register, set BUSY=1 and enter ADDR.
REQ-015 T_STB SHALL be ignored whenever BUSY=1.
REQ-016 MDIO_OUT and MDIO_OE SHALL change only on the CLK edge that drives MDC 1->0; bits are sent MSB first, one bit per MDC period.
REQ-017 Bit 31 SHALL appear on the first MDC falling edge after capture; capture-to-first-bit latency is at most 2 CLK cycles.
REQ-018 No preamble SHALL be sent; the frame starts directly with ST.
REQ-019 A 6-bit counter SHALL count the bits sent, 0..31.
REQ-020 ADDR SHALL drive bits 31..18 (14 bits) with MDIO_OE=1.
REQ-021 After ADDR, OP=2'b10 SHALL enter TURN; every other OP value (01, 00, 11) SHALL enter WRITE.
REQ-022 WRITE SHALL drive bits 17..0 with MDIO_OE=1, giving 32 driven bits in total, then go to DONE.
REQ-023 TURN SHALL last 2 MDC periods with MDIO_OE=0 and MDIO_OUT=0.
REQ-024 READ SHALL last 16 MDC periods with MDIO_OE=0.
REQ-025 In READ, MDIO_IN SHALL be sampled on the CLK edge that drives MDC 0->1 and shifted into RD_DATA MSB first.
REQ-026 RD_DATA SHALL hold its last value until the next read completes; writes SHALL NOT alter RD_DATA.
REQ-027 DONE SHALL last 1 CLK with MDIO_OE=0 and BUSY=0.
REQ-028 DONE SHALL pulse DATA_RDY for 1 CLK only when the frame was a read, then return to IDLE.
REQ-029 A T_STB asserted in the DONE cycle SHALL be accepted in the following IDLE cycle, if it is still high.
REQ-030 Total frame length SHALL be 32 MDC periods (64 CLK), excluding alignment.

Reset
REQ-031 With RESET=0, outputs SHALL be MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0.
REQ-032 With RESET=0, the counter SHALL be cleared and the state SHALL be IDLE.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately, asynchronously, and no DATA_RDY SHALL follow.
REQ-034 The first MDC toggle SHALL occur on the first CLK rising edge after RESET returns high.

Structure
REQ-035 Shared package mdio_pkg SHALL hold OP_READ=2'b10, OP_WRITE=2'b01, FRAME_LEN=32, ADDR_BITS=14, DATA_BITS=16 and the state encoding.
REQ-036 The receptor and its testers SHALL reuse mdio_pkg.
REQ-037 One sub-module, mdio_clk_gen, SHALL generate MDC plus one-CLK strobes mdc_fall and mdc_rise; the FSM and shifters live in mdio_controller.

Verification
REQ-038 Write: T_DATA=32'h5086_8FF1 with T_STB pulse -> 32 bits 0101_0000_1000_0110_1000_1111_1111_0001 on MDIO_OUT, MDIO_OE=1 for 32 MDC periods, DATA_RDY stays 0, BUSY falls after 64+ CLK.
REQ-039 Read: T_DATA=32'h6086_0000, PHY returns 16'h8FF1 on MDIO_IN -> MDIO_OE=1 for 14 periods then 0; RD_DATA=16'h8FF1 with one DATA_RDY pulse.
REQ-040 Busy: T_STB with T_DATA=32'h5FFF_FFFF pulsed at bit 5 of an active write -> ignored; the original frame completes unchanged.
REQ-041 Reset mid-frame: RESET=0 at bit 10 of a read -> all outputs zero at once, no DATA_RDY; a new read after release completes normally.
REQ-042 Back-to-back: T_STB held high across a read followed by a write -> second frame starts within 3 CLK of DONE; RD_DATA keeps the read value.
REQ-043 Invalid OP: T_DATA=32'h4000_1234 (OP=00) -> driven as a write for all 32 bits; no DATA_RDY.
